// File: rtl/wait_mem.sv
// wait_mem: synchronous word-addressed memory with byte-lane writes and a
// configurable read latency. A read is sampled at the accept edge and
// delivered LATENCY cycles later with a one-cycle rvalid pulse. Any request
// seen while busy is high is ignored, including its write.
module wait_mem #(
    parameter int unsigned AWIDTH     = 30,
    parameter int unsigned DWIDTH     = 32,
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned LATENCY    = 1,
    parameter string       INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  re,
    input  logic                  we,
    input  logic [DWIDTH/8-1:0]   be,
    input  logic [AWIDTH-1:0]     addr,
    input  logic [DWIDTH-1:0]     wdata,
    output logic [DWIDTH-1:0]     rdata,
    output logic                  rvalid,
    output logic                  busy
);

    localparam int unsigned NBYTES   = DWIDTH / 8;
    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("wait_mem: LATENCY must be in 1..15");
    end
    if (DWIDTH % 8 != 0) begin : g_bad_dwidth
        $error("wait_mem: DWIDTH must be a multiple of 8");
    end

    // Upper address bits alias onto the stored range and are deliberately ignored.
    if (AWIDTH > DEPTH_LOG2) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^addr[AWIDTH-1:DEPTH_LOG2];
    end

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_e;

    logic [DWIDTH-1:0]     mem [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0] idx;
    logic [DWIDTH-1:0]     rd_word;
    logic                  accept;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              rvalid_q, rvalid_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic [DWIDTH-1:0] hold_q, hold_d;

    assign idx     = addr[DEPTH_LOG2-1:0];
    assign rd_word = mem[idx];
    assign accept  = rst && !busy_q && (re || we);

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign busy   = busy_q;

    // Byte-lane write commit on the accept edge; the array is never reset.
    always_ff @(posedge clk) begin
        if (accept && we) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Next-state logic for the read path: direct return at LATENCY=1,
    // otherwise hold the sampled word and count down the wait states.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        hold_d   = hold_q;
        if (LATENCY == 1) begin
            if (accept && re) begin
                rdata_d  = rd_word;
                rvalid_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && re) begin
                        hold_d  = rd_word;
                        cnt_d   = CNT_LOAD;
                        busy_d  = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state_d  = ST_IDLE;
                        cnt_d    = '0;
                        busy_d   = 1'b0;
                        rdata_d  = hold_q;
                        rvalid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // Control and output registers; reset discards any outstanding read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            hold_q   <= hold_d;
        end
    end

endmodule

// File: tb/tb_wait_mem.sv
// tb_wait_mem: three wait_mem instances (LATENCY 1, 3, 4) checked every
// cycle against a transaction-level model, plus a table of directed vectors
// and hand-written reset / latency sequences.
module tb_wait_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        re_i    [3];
    logic        we_i    [3];
    logic [3:0]  be_i    [3];
    logic [29:0] addr_i  [3];
    logic [31:0] wdata_i [3];
    logic [31:0] rdata_o [3];
    logic        rvalid_o[3];
    logic        busy_o  [3];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wait_mem #(.LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .re(re_i[0]), .we(we_i[0]), .be(be_i[0]),
        .addr(addr_i[0]), .wdata(wdata_i[0]), .rdata(rdata_o[0]),
        .rvalid(rvalid_o[0]), .busy(busy_o[0]));

    wait_mem #(.LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .re(re_i[1]), .we(we_i[1]), .be(be_i[1]),
        .addr(addr_i[1]), .wdata(wdata_i[1]), .rdata(rdata_o[1]),
        .rvalid(rvalid_o[1]), .busy(busy_o[1]));

    wait_mem #(.LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .re(re_i[2]), .we(we_i[2]), .be(be_i[2]),
        .addr(addr_i[2]), .wdata(wdata_i[2]), .rdata(rdata_o[2]),
        .rvalid(rvalid_o[2]), .busy(busy_o[2]));

    // Reference model: memory image plus one outstanding read tracked by age.
    int        lat[3] = '{1, 3, 4};
    bit [31:0] mm[3][256];
    bit        pv[3];
    int        page[3];
    bit [31:0] pdata[3];
    bit [31:0] e_rdata[3];
    bit        e_rv[3];
    bit        e_busy[3];

    function automatic void model_edge(int k);
        int idx;
        bit was_busy;
        if (!rst) begin
            pv[k] = 0; e_rdata[k] = '0; e_rv[k] = 0; e_busy[k] = 0;
            return;
        end
        was_busy = e_busy[k];
        e_rv[k]  = 0;
        idx = int'(addr_i[k] % 256);
        if (!was_busy && (re_i[k] || we_i[k])) begin
            if (re_i[k]) begin
                pv[k] = 1; page[k] = 0; pdata[k] = mm[k][idx];
            end
            if (we_i[k]) begin
                for (int i = 0; i < 4; i++)
                    if (be_i[k][i]) mm[k][idx][8*i +: 8] = wdata_i[k][8*i +: 8];
            end
        end
        if (pv[k]) begin
            page[k]++;
            if (page[k] == lat[k]) begin
                e_rv[k] = 1; e_rdata[k] = pdata[k]; pv[k] = 0;
            end
        end
        e_busy[k] = pv[k];
    endfunction

    task automatic chk(string name, int k, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d got=%h expected=%h t=%0t", name, k, got, exp, $time);
        end
    endtask

    // One clock edge: advance the model on the sampled inputs, then compare.
    task automatic step();
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_edge(k);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("model_rvalid", k, 32'(rvalid_o[k]), 32'(e_rv[k]));
            chk("model_busy",   k, 32'(busy_o[k]),   32'(e_busy[k]));
            chk("model_rdata",  k, rdata_o[k],       e_rdata[k]);
        end
    endtask

    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            re_i[k] = 0; we_i[k] = 0; be_i[k] = '0; addr_i[k] = '0; wdata_i[k] = '0;
        end
    endtask

    typedef struct {
        int        inst;
        bit        re;
        bit        we;
        bit [3:0]  be;
        bit [29:0] addr;
        bit [31:0] wdata;
        bit        ev;
        bit        eb;
        bit [31:0] ed;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(int inst, bit r, bit w, bit [3:0] b, bit [29:0] a,
                                bit [31:0] wd, bit ev, bit eb, bit [31:0] ed);
        vec_t v;
        v.inst = inst; v.re = r; v.we = w; v.be = b; v.addr = a; v.wdata = wd;
        v.ev = ev; v.eb = eb; v.ed = ed;
        tbl.push_back(v);
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog expired got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst = 1'b0;
        idle_all();

        // LATENCY=1: preload, back-to-back reads, byte lanes, re+we, alias
        add(0, 0, 1, 4'hF, 30'd0, 32'h11111111, 0, 0, 32'h0);
        add(0, 0, 1, 4'hF, 30'd1, 32'h22222222, 0, 0, 32'h0);
        add(0, 0, 1, 4'hF, 30'd2, 32'h33333333, 0, 0, 32'h0);
        add(0, 0, 1, 4'hF, 30'd3, 32'h44444444, 0, 0, 32'h0);
        add(0, 1, 0, 4'h0, 30'd0, 32'h0, 1, 0, 32'h11111111);
        add(0, 1, 0, 4'h0, 30'd1, 32'h0, 1, 0, 32'h22222222);
        add(0, 1, 0, 4'h0, 30'd2, 32'h0, 1, 0, 32'h33333333);
        add(0, 1, 0, 4'h0, 30'd3, 32'h0, 1, 0, 32'h44444444);
        add(0, 0, 0, 4'h0, 30'd0, 32'h0, 0, 0, 32'h44444444);
        add(0, 0, 1, 4'hF, 30'd7, 32'h00000000, 0, 0, 32'h44444444);
        add(0, 0, 1, 4'h5, 30'd7, 32'hDEADBEEF, 0, 0, 32'h44444444);
        add(0, 1, 0, 4'h0, 30'd7, 32'h0, 1, 0, 32'h00AD00EF);
        add(0, 0, 1, 4'h0, 30'd7, 32'hFFFFFFFF, 0, 0, 32'h00AD00EF);
        add(0, 1, 0, 4'h0, 30'd7, 32'h0, 1, 0, 32'h00AD00EF);
        add(0, 0, 1, 4'hF, 30'd9, 32'h12345678, 0, 0, 32'h00AD00EF);
        add(0, 1, 1, 4'hF, 30'd9, 32'hCAFEF00D, 1, 0, 32'h12345678);
        add(0, 1, 0, 4'h0, 30'd9, 32'h0, 1, 0, 32'hCAFEF00D);
        add(0, 1, 0, 4'h0, 30'd265, 32'h0, 1, 0, 32'hCAFEF00D);
        // LATENCY=3: wait states, held second request, re+we
        add(1, 0, 1, 4'hF, 30'd5, 32'hA5A5A5A5, 0, 0, 32'h0);
        add(1, 1, 0, 4'h0, 30'd5, 32'h0, 0, 1, 32'h0);
        add(1, 1, 0, 4'h0, 30'd6, 32'h0, 0, 1, 32'h0);
        add(1, 1, 0, 4'h0, 30'd6, 32'h0, 1, 0, 32'hA5A5A5A5);
        add(1, 1, 0, 4'h0, 30'd6, 32'h0, 0, 1, 32'hA5A5A5A5);
        add(1, 0, 0, 4'h0, 30'd0, 32'h0, 0, 1, 32'hA5A5A5A5);
        add(1, 0, 0, 4'h0, 30'd0, 32'h0, 1, 0, 32'hC0DE0006);
        add(1, 1, 1, 4'hF, 30'd9, 32'hCAFEF00D, 0, 1, 32'hC0DE0006);
        add(1, 0, 0, 4'h0, 30'd0, 32'h0, 0, 1, 32'hC0DE0006);
        add(1, 0, 0, 4'h0, 30'd0, 32'h0, 1, 0, 32'hC0DE0009);
        add(1, 1, 0, 4'h0, 30'd9, 32'h0, 0, 1, 32'hC0DE0009);
        add(1, 0, 0, 4'h0, 30'd0, 32'h0, 0, 1, 32'hC0DE0009);
        add(1, 0, 0, 4'h0, 30'd0, 32'h0, 1, 0, 32'hCAFEF00D);
        // LATENCY=4: writes dropped while busy, address aliasing
        add(2, 1, 0, 4'h0, 30'd2, 32'h0, 0, 1, 32'h0);
        add(2, 0, 1, 4'hF, 30'd2, 32'hFFFFFFFF, 0, 1, 32'h0);
        add(2, 0, 1, 4'hF, 30'd258, 32'hFFFFFFFF, 0, 1, 32'h0);
        add(2, 0, 0, 4'h0, 30'd0, 32'h0, 1, 0, 32'hC0DE0002);
        add(2, 1, 0, 4'h0, 30'd258, 32'h0, 0, 1, 32'hC0DE0002);
        add(2, 0, 0, 4'h0, 30'd0, 32'h0, 0, 1, 32'hC0DE0002);
        add(2, 0, 0, 4'h0, 30'd0, 32'h0, 0, 1, 32'hC0DE0002);
        add(2, 0, 0, 4'h0, 30'd0, 32'h0, 1, 0, 32'hC0DE0002);
        add(2, 0, 1, 4'hF, 30'd258, 32'h13572468, 0, 0, 32'hC0DE0002);
        add(2, 1, 0, 4'h0, 30'd2, 32'h0, 0, 1, 32'hC0DE0002);
        add(2, 0, 0, 4'h0, 30'd0, 32'h0, 0, 1, 32'hC0DE0002);
        add(2, 0, 0, 4'h0, 30'd0, 32'h0, 0, 1, 32'hC0DE0002);
        add(2, 0, 0, 4'h0, 30'd0, 32'h0, 1, 0, 32'h13572468);

        // Reset, then fill every word with a known pattern
        for (int i = 0; i < 3; i++) step();
        for (int k = 0; k < 3; k++) begin
            chk("reset_rvalid", k, 32'(rvalid_o[k]), 32'h0);
            chk("reset_busy",   k, 32'(busy_o[k]),   32'h0);
            chk("reset_rdata",  k, rdata_o[k],       32'h0);
        end
        #2 rst = 1'b1;
        for (int w = 0; w < 256; w++) begin
            for (int k = 0; k < 3; k++) begin
                we_i[k] = 1; be_i[k] = 4'hF; addr_i[k] = 30'(w); wdata_i[k] = 32'hC0DE0000 + 32'(w);
            end
            step();
        end
        idle_all();
        step();

        // Directed vector table
        foreach (tbl[r]) begin
            idle_all();
            re_i[tbl[r].inst]    = tbl[r].re;
            we_i[tbl[r].inst]    = tbl[r].we;
            be_i[tbl[r].inst]    = tbl[r].be;
            addr_i[tbl[r].inst]  = tbl[r].addr;
            wdata_i[tbl[r].inst] = tbl[r].wdata;
            step();
            chk("vec_rvalid", tbl[r].inst, 32'(rvalid_o[tbl[r].inst]), 32'(tbl[r].ev));
            chk("vec_busy",   tbl[r].inst, 32'(busy_o[tbl[r].inst]),   32'(tbl[r].eb));
            chk("vec_rdata",  tbl[r].inst, rdata_o[tbl[r].inst],       tbl[r].ed);
        end
        idle_all();
        step();

        // Reset two cycles into a LATENCY=4 read
        re_i[2] = 1; addr_i[2] = 30'd2;
        step();
        idle_all();
        step();
        rst = 1'b0;
        step();
        chk("midrst_busy",   2, 32'(busy_o[2]),   32'h0);
        chk("midrst_rvalid", 2, 32'(rvalid_o[2]), 32'h0);
        chk("midrst_rdata",  2, rdata_o[2],       32'h0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("no_rvalid_after_rst", 2, 32'(rvalid_o[2]), 32'h0);
        end

        // Fresh read after reset completes with full latency
        re_i[2] = 1; addr_i[2] = 30'd2;
        step();
        idle_all();
        c = 1;
        while (rvalid_o[2] !== 1'b1 && c < 12) begin
            step();
            c++;
        end
        chk("fresh_rvalid",  2, 32'(rvalid_o[2]), 32'h1);
        chk("fresh_latency", 2, 32'(c),           32'd4);
        chk("fresh_rdata",   2, rdata_o[2],       32'h13572468);

        // Randomised traffic with occasional resets
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 99) != 0);
            for (int k = 0; k < 3; k++) begin
                re_i[k]    = ($urandom_range(0, 2) == 0);
                we_i[k]    = ($urandom_range(0, 2) == 0);
                be_i[k]    = 4'($urandom);
                addr_i[k]  = (30'($urandom) & 30'h3FFFFF00) | 30'($urandom_range(0, 15));
                wdata_i[k] = $urandom;
            end
            step();
        end
        rst = 1'b1;
        idle_all();
        for (int i = 0; i < 6; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
